// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state codes and datapath select encodings for the multicycle MIPS control
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state/mem_ready to datapath control decoder
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                // IR load and PC+4 only commit on the cycle the memory returns data
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with memory-ready stall
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;

    logic dec_pc_write;
    logic dec_pc_write_cond;
    logic dec_mem_read;
    logic dec_mem_write;
    logic dec_ir_write;
    logic dec_reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_R:         state_q <= S_EXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default: begin
                            state_q <= S_FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ALUWB:  state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_ADDIWB: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign state = state_q;

    mips_ctrl_outdec u_outdec (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (dec_pc_write),
        .pc_write_cond (dec_pc_write_cond),
        .iord          (iord),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .ir_write      (dec_ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (dec_reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

    // Strobes are masked by reset itself so an abort never leaves a write pending
    assign pc_write      = dec_pc_write      & rst_n;
    assign pc_write_cond = dec_pc_write_cond & rst_n;
    assign mem_read      = dec_mem_read      & rst_n;
    assign mem_write     = dec_mem_write     & rst_n;
    assign ir_write      = dec_ir_write      & rst_n;
    assign reg_write     = dec_reg_write     & rst_n;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle MIPS control FSM
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   pend_ill = 1'b0;

    logic [15:0] act_outs;
    assign act_outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk(bit pw, bit pwc, bit io, bit mrd, bit mwr, bit irw,
                                       bit rd, bit m2r, bit rw, bit sa,
                                       logic [1:0] sb, logic [1:0] ao, logic [1:0] ps);
        return {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ps};
    endfunction

    // Output table written straight from the per-state behaviour list
    function automatic logic [15:0] exp_outs(int st, bit mr);
        case (st)
            0:  return pk(mr,0,0,1,0,mr, 0,0,0,0, 2'b01, 2'b00, 2'b00);
            1:  return pk(0,0,0,0,0,0,   0,0,0,0, 2'b11, 2'b00, 2'b00);
            2:  return pk(0,0,0,0,0,0,   0,0,0,1, 2'b10, 2'b00, 2'b00);
            3:  return pk(0,0,1,1,0,0,   0,0,0,0, 2'b00, 2'b00, 2'b00);
            4:  return pk(0,0,0,0,0,0,   0,1,1,0, 2'b00, 2'b00, 2'b00);
            5:  return pk(0,0,1,0,1,0,   0,0,0,0, 2'b00, 2'b00, 2'b00);
            6:  return pk(0,0,0,0,0,0,   0,0,0,1, 2'b00, 2'b10, 2'b00);
            7:  return pk(0,0,0,0,0,0,   1,0,1,0, 2'b00, 2'b00, 2'b00);
            8:  return pk(0,1,0,0,0,0,   0,0,0,1, 2'b00, 2'b01, 2'b01);
            9:  return pk(0,0,0,0,0,0,   0,0,0,1, 2'b10, 2'b00, 2'b00);
            10: return pk(0,0,0,0,0,0,   0,0,1,0, 2'b00, 2'b00, 2'b00);
            11: return pk(1,0,0,0,0,0,   0,0,0,0, 2'b00, 2'b00, 2'b10);
            default: return 16'h0;
        endcase
    endfunction

    // One clock of stimulus: drive inputs, record what the DUT must show, advance
    task automatic cyc(input int st, input bit mr, input logic [5:0] op);
        exp_t e;
        mem_ready = mr;
        opcode    = op;
        e.st   = 4'(st);
        e.outs = exp_outs(st, mr);
        e.ill  = pend_ill;
        pend_ill = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic bit rnd_mr(bit tie);
        return tie ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Whole instruction from the architectural view: fetch, decode, then the class-specific steps
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit tie);
        for (int i = 0; i < wf; i++) cyc(0, 1'b0, junk());
        cyc(0, 1'b1, junk());
        cyc(1, rnd_mr(tie), op);
        if (op == 6'b100011) begin
            cyc(2, rnd_mr(tie), op);
            for (int i = 0; i < wm; i++) cyc(3, 1'b0, junk());
            cyc(3, 1'b1, junk());
            cyc(4, rnd_mr(tie), junk());
        end else if (op == 6'b101011) begin
            cyc(2, rnd_mr(tie), op);
            for (int i = 0; i < wm; i++) cyc(5, 1'b0, junk());
            cyc(5, 1'b1, junk());
        end else if (op == 6'b000000) begin
            cyc(6, rnd_mr(tie), junk());
            cyc(7, rnd_mr(tie), junk());
        end else if (op == 6'b000100) begin
            cyc(8, rnd_mr(tie), junk());
        end else if (op == 6'b001000) begin
            cyc(9, rnd_mr(tie), junk());
            cyc(10, rnd_mr(tie), junk());
        end else if (op == 6'b000010) begin
            cyc(11, rnd_mr(tie), junk());
        end else begin
            pend_ill = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 16'(state), 16'(e.st));
            chk("outputs", act_outs, e.outs);
            chk("illegal", 16'(illegal), 16'(e.ill));
        end
    end

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b111111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_strobes", 16'({mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal}), 16'd0);
        chk("reset_selects", 16'({iord, alu_src_a, alu_src_b, alu_op, pc_source}), 16'b0_0_01_00_00);
        rst_n = 1'b1;

        run_instr(6'b000000, 0, 0, 1'b1);
        run_instr(6'b100011, 0, 2, 1'b0);
        run_instr(6'b101011, 1, 1, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b000000, 2, 0, 1'b0);

        // Abort a store in MEMWR with an asynchronous reset
        cyc(0, 1'b1, junk());
        cyc(1, 1'b0, 6'b101011);
        cyc(2, 1'b1, 6'b101011);
        begin
            exp_t e;
            mem_ready = 1'b0;
            opcode = junk();
            e.st = 4'd5; e.outs = exp_outs(5, 1'b0); e.ill = 1'b0;
            q.push_back(e);
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_mem_write", 16'(mem_write), 16'd0);
            chk("abort_state", 16'(state), 16'd0);
            @(posedge clk);
            #1;
            chk("abort_hold", 16'({state, mem_read, ir_write, pc_write, illegal}), 16'd0);
            rst_n = 1'b1;
            pend_ill = 1'b0;
        end

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 7));
            op = (sel < 6) ? legal_ops[sel] : junk();
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
        cyc(0, 1'b0, junk());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
